// File: rtl/fan_tach_alarm_if.sv
// Tach inputs, mask and alarm outputs of the fan monitor, bundled for the display CPLD.
interface fan_tach_alarm_if #(
   parameter int FAN_NUM = 4
);
   logic               Strobe16ms;
   logic [FAN_NUM-1:0] FanTach;
   logic [FAN_NUM-1:0] FanMask;
   logic [FAN_NUM-1:0] FanFailStatus;
   logic               Beep;

   modport master (
      output Strobe16ms,
      output FanTach,
      output FanMask,
      input  FanFailStatus,
      input  Beep
   );

   modport slave (
      input  Strobe16ms,
      input  FanTach,
      input  FanMask,
      output FanFailStatus,
      output Beep
   );
endinterface

// File: rtl/fan_tach_alarm.sv
// Fan tachometer monitor: counts tach edges per window of 16 ms strobes, debounces
// per-fan failure and drives the fan-fail Beep cadence for the status LED logic.
module fan_tach_alarm #(
   parameter int FAN_NUM          = 4,
   parameter int WINDOW_STROBES   = 64,
   parameter int MIN_PULSES       = 8,
   parameter int FAIL_WINDOWS     = 2,
   parameter int SPINUP_WINDOWS   = 4,
   parameter int BEEP_ON_STROBES  = 1,
   parameter int BEEP_OFF_STROBES = 1
) (
   input  logic            SlowClock,
   input  logic            Reset,
   fan_tach_alarm_if.slave tachBus
);
   // A 64-strobe window wraps the 6-bit counter from 63 back to 0.
   localparam logic [5:0] WIN_LAST   = 6'(WINDOW_STROBES - 1);
   localparam logic [7:0] MIN_CNT    = 8'(MIN_PULSES);
   localparam logic [1:0] DEB_MAX    = 2'(FAIL_WINDOWS);
   localparam logic [3:0] SPIN_LAST  = 4'(SPINUP_WINDOWS - 1);
   localparam int         PHASE_LEN  = BEEP_ON_STROBES + BEEP_OFF_STROBES;
   localparam logic [2:0] PHASE_LAST = 3'(PHASE_LEN - 1);
   localparam logic [2:0] PHASE_ON   = 3'(BEEP_ON_STROBES);

   typedef enum logic [1:0] {
      SPINUP,
      MONITOR,
      ALARM
   } stateType;

   stateType           state_reg;
   logic [FAN_NUM-1:0] tachSync1_reg;
   logic [FAN_NUM-1:0] tachSync2_reg;
   logic [FAN_NUM-1:0] tachSync3_reg;
   logic [FAN_NUM-1:0] tachRise;
   logic [FAN_NUM-1:0] failStatus_next;
   logic [FAN_NUM-1:0] failStatus_reg;
   logic [5:0]         winCnt_reg;
   logic [3:0]         spinCnt_reg;
   logic [2:0]         phase_reg;
   logic               beep_reg;
   logic               windowEnd;
   logic               evalActive;

   assign tachRise   = tachSync2_reg & ~tachSync3_reg;
   assign windowEnd  = tachBus.Strobe16ms && (winCnt_reg == WIN_LAST);
   assign evalActive = windowEnd && (state_reg != SPINUP);

   always_ff @(posedge SlowClock) begin
      if (Reset) begin
         tachSync1_reg <= '0;
         tachSync2_reg <= '0;
         tachSync3_reg <= '0;
      end else begin
         tachSync1_reg <= tachBus.FanTach;
         tachSync2_reg <= tachSync1_reg;
         tachSync3_reg <= tachSync2_reg;
      end
   end

   always_ff @(posedge SlowClock) begin
      if (Reset) begin
         winCnt_reg <= '0;
      end else if (tachBus.Strobe16ms) begin
         winCnt_reg <= windowEnd ? 6'd0 : winCnt_reg + 6'd1;
      end
   end

   generate
      for (genvar gi = 0; gi < FAN_NUM; gi++) begin : g_fan
         logic [7:0] edgeCnt_reg;
         logic [1:0] deb_reg;
         logic [1:0] deb_next;

         // Mask wins over everything; SPINUP keeps the debouncer parked at zero.
         always_comb begin
            deb_next = deb_reg;
            if (tachBus.FanMask[gi] || (state_reg == SPINUP)) begin
               deb_next = '0;
            end else if (evalActive) begin
               if (edgeCnt_reg < MIN_CNT) begin
                  deb_next = (deb_reg == DEB_MAX) ? DEB_MAX : deb_reg + 2'd1;
               end else begin
                  deb_next = '0;
               end
            end
         end

         // An edge landing on the window-end cycle is credited to the new window.
         always_ff @(posedge SlowClock) begin
            if (Reset) begin
               edgeCnt_reg <= '0;
               deb_reg     <= '0;
            end else begin
               if (windowEnd) begin
                  edgeCnt_reg <= {7'd0, tachRise[gi]};
               end else if (tachRise[gi] && (edgeCnt_reg != 8'hFF)) begin
                  edgeCnt_reg <= edgeCnt_reg + 8'd1;
               end
               deb_reg <= deb_next;
            end
         end

         assign failStatus_next[gi] = (deb_next == DEB_MAX);
      end
   endgenerate

   always_ff @(posedge SlowClock) begin
      if (Reset) begin
         failStatus_reg <= '0;
      end else begin
         failStatus_reg <= failStatus_next;
      end
   end

   always_ff @(posedge SlowClock) begin
      if (Reset) begin
         state_reg   <= SPINUP;
         spinCnt_reg <= '0;
         phase_reg   <= '0;
         beep_reg    <= 1'b0;
      end else begin
         case (state_reg)
            SPINUP: begin
               beep_reg  <= 1'b0;
               phase_reg <= '0;
               if (windowEnd) begin
                  if (spinCnt_reg == SPIN_LAST) begin
                     state_reg   <= MONITOR;
                     spinCnt_reg <= '0;
                  end else begin
                     spinCnt_reg <= spinCnt_reg + 4'd1;
                  end
               end
            end
            MONITOR: begin
               phase_reg <= '0;
               if (|failStatus_reg) begin
                  state_reg <= ALARM;
                  beep_reg  <= 1'b1;
               end else begin
                  beep_reg <= 1'b0;
               end
            end
            ALARM: begin
               if (failStatus_reg == '0) begin
                  state_reg <= MONITOR;
                  beep_reg  <= 1'b0;
                  phase_reg <= '0;
               end else if (tachBus.Strobe16ms) begin
                  // Phase 0..ON-1 sounds, the rest of the cycle is silent.
                  if (phase_reg == PHASE_LAST) begin
                     phase_reg <= '0;
                     beep_reg  <= 1'b1;
                  end else begin
                     phase_reg <= phase_reg + 3'd1;
                     beep_reg  <= ((phase_reg + 3'd1) < PHASE_ON);
                  end
               end
            end
            default: begin
               state_reg   <= SPINUP;
               spinCnt_reg <= '0;
               phase_reg   <= '0;
               beep_reg    <= 1'b0;
            end
         endcase
      end
   end

   assign tachBus.FanFailStatus = failStatus_reg;
   assign tachBus.Beep          = beep_reg;
endmodule

// File: tb/tb_fan_tach_alarm.sv
// Randomized and directed check of fan_tach_alarm against a window-level reference model.
module tb_fan_tach_alarm;
   localparam int FAN_NUM  = 4;
   localparam int WIN      = 64;
   localparam int MINP     = 8;
   localparam int FAILW    = 2;
   localparam int SPINW    = 4;
   localparam int BEEP_ON  = 1;
   localparam int BEEP_OFF = 1;
   localparam int STROBE_PERIOD = 4;

   logic SlowClock = 1'b0;
   logic Reset     = 1'b1;
   int   checks    = 0;
   int   failures  = 0;

   fan_tach_alarm_if #(.FAN_NUM(FAN_NUM)) bus ();

   fan_tach_alarm #(
      .FAN_NUM(FAN_NUM), .WINDOW_STROBES(WIN), .MIN_PULSES(MINP),
      .FAIL_WINDOWS(FAILW), .SPINUP_WINDOWS(SPINW),
      .BEEP_ON_STROBES(BEEP_ON), .BEEP_OFF_STROBES(BEEP_OFF)
   ) dut (
      .SlowClock(SlowClock),
      .Reset(Reset),
      .tachBus(bus)
   );

   always #5 SlowClock = ~SlowClock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (window / count level) ----------------
   bit                 modelValid = 0;
   logic [FAN_NUM-1:0] tachD1, tachD2, tachD3;
   int                 winStrobes, windowsDone, alarmStrobes;
   int                 edgesInWin [FAN_NUM];
   int                 failRun    [FAN_NUM];
   bit                 inAlarm;
   logic [FAN_NUM-1:0] expStatus;
   logic               expBeep;

   task automatic modelStep();
      logic [FAN_NUM-1:0] rising, prevStatus, nextStatus;
      bit winEnd, monitoring;
      if (Reset) begin
         tachD1 = '0; tachD2 = '0; tachD3 = '0;
         winStrobes = 0; windowsDone = 0; alarmStrobes = 0;
         for (int i = 0; i < FAN_NUM; i++) begin
            edgesInWin[i] = 0;
            failRun[i] = 0;
         end
         inAlarm = 0; expStatus = '0; expBeep = 1'b0;
         modelValid = 1;
         return;
      end
      if (!modelValid) return;
      // A tach rise is seen by the counter after the input has passed three flops.
      rising = tachD2 & ~tachD3;
      tachD3 = tachD2; tachD2 = tachD1; tachD1 = bus.FanTach;
      prevStatus = expStatus;
      winEnd = bus.Strobe16ms && (winStrobes == WIN - 1);
      monitoring = (windowsDone >= SPINW);
      for (int i = 0; i < FAN_NUM; i++) begin
         if (winEnd) begin
            if (monitoring) begin
               if (edgesInWin[i] < MINP && !bus.FanMask[i])
                  failRun[i] = (failRun[i] + 1 > FAILW) ? FAILW : failRun[i] + 1;
               else
                  failRun[i] = 0;
            end
            edgesInWin[i] = rising[i] ? 1 : 0;
         end else begin
            edgesInWin[i] += rising[i] ? 1 : 0;
         end
         if (bus.FanMask[i]) failRun[i] = 0;
         nextStatus[i] = (failRun[i] == FAILW);
      end
      if (bus.Strobe16ms) winStrobes = winEnd ? 0 : winStrobes + 1;
      if (winEnd && windowsDone < 1000) windowsDone++;
      if (!inAlarm) begin
         if (prevStatus != '0) begin
            inAlarm = 1; alarmStrobes = 0; expBeep = 1'b1;
         end
      end else if (prevStatus == '0) begin
         inAlarm = 0; expBeep = 1'b0;
      end else if (bus.Strobe16ms) begin
         alarmStrobes++;
         expBeep = ((alarmStrobes % (BEEP_ON + BEEP_OFF)) < BEEP_ON);
      end
      expStatus = nextStatus;
   endtask

   initial forever begin
      @(posedge SlowClock);
      modelStep();
   end

   initial forever begin
      @(negedge SlowClock);
      if (modelValid) begin
         check("status_vs_model", 32'(bus.FanFailStatus), 32'(expStatus));
         check("beep_vs_model", 32'(bus.Beep), 32'(expBeep));
      end
   end

   // ---------------- stimulus ----------------
   int cyc = 0, strobeIdx = 0, winEnds = 0;
   int hiT [FAN_NUM];
   int loT [FAN_NUM];
   int gCnt [FAN_NUM];
   logic [FAN_NUM-1:0] tachV = '0;

   task automatic setFan(input int i, input int h, input int l);
      hiT[i] = h;
      loT[i] = l;
   endtask

   task automatic step(input bit rstVal);
      @(negedge SlowClock); #1;
      Reset = rstVal;
      bus.Strobe16ms = 1'b0;
      if (rstVal) begin
         cyc = 0; strobeIdx = 0; winEnds = 0;
      end else begin
         if (cyc % STROBE_PERIOD == STROBE_PERIOD - 1) begin
            bus.Strobe16ms = 1'b1;
            if (strobeIdx % WIN == WIN - 1) winEnds++;
            strobeIdx++;
         end
         cyc++;
      end
      for (int i = 0; i < FAN_NUM; i++) begin
         if (hiT[i] == 0) begin
            tachV[i] = 1'b0; gCnt[i] = 0;
         end else begin
            gCnt[i]++;
            if (tachV[i] && gCnt[i] >= hiT[i]) begin
               tachV[i] = 1'b0; gCnt[i] = 0;
            end else if (!tachV[i] && gCnt[i] >= loT[i]) begin
               tachV[i] = 1'b1; gCnt[i] = 0;
            end
         end
      end
      bus.FanTach = tachV;
   endtask

   // Returns one cycle after the posedge that sampled window end number tgt.
   task automatic stepUntilWin(input int tgt);
      while (winEnds < tgt) step(1'b0);
      step(1'b0);
   endtask

   task automatic stepUntilStrobe();
      int s;
      s = strobeIdx;
      while (strobeIdx == s) step(1'b0);
      step(1'b0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int tgt;
      bus.Strobe16ms = 1'b0; bus.FanTach = '0; bus.FanMask = '0;
      for (int i = 0; i < FAN_NUM; i++) begin
         setFan(i, 6, 6);
         gCnt[i] = 0;
      end

      // Healthy fans through SPINUP plus 10 windows.
      step(1'b1); step(1'b1);
      step(1'b0);
      check("reset_status", 32'(bus.FanFailStatus), 32'h0);
      check("reset_beep", 32'(bus.Beep), 32'h0);
      stepUntilWin(2);
      check("spinup_status", 32'(bus.FanFailStatus), 32'h0);
      stepUntilWin(SPINW + 10);
      check("healthy_status", 32'(bus.FanFailStatus), 32'h0);
      check("healthy_beep", 32'(bus.Beep), 32'h0);

      // Fan 2 stops: fails after two windows, Beep follows, then toggles per strobe.
      setFan(2, 0, 0);
      tgt = winEnds + 1;
      stepUntilWin(tgt);
      check("fan2_one_window", 32'(bus.FanFailStatus), 32'h0);
      stepUntilWin(tgt + 1);
      check("fan2_fail_status", 32'(bus.FanFailStatus), 32'h4);
      check("fan2_beep_not_yet", 32'(bus.Beep), 32'h0);
      step(1'b0);
      check("fan2_beep_rise", 32'(bus.Beep), 32'h1);
      stepUntilStrobe();
      check("cadence_off", 32'(bus.Beep), 32'h0);
      stepUntilStrobe();
      check("cadence_on", 32'(bus.Beep), 32'h1);

      // Exactly MIN_PULSES per window passes; a slower fan fails; recovery clears.
      setFan(2, 16, 16);
      stepUntilWin(winEnds + 4);
      check("fan2_8_edges_status", 32'(bus.FanFailStatus), 32'h0);
      check("fan2_8_edges_beep", 32'(bus.Beep), 32'h0);
      setFan(2, 18, 19);
      stepUntilWin(winEnds + 3);
      check("fan2_7_edges_status", 32'(bus.FanFailStatus), 32'h4);
      setFan(2, 6, 6);
      stepUntilWin(winEnds + 1);
      check("fan2_recover_status", 32'(bus.FanFailStatus), 32'h0);
      step(1'b0);
      check("fan2_recover_beep", 32'(bus.Beep), 32'h0);

      // Fan 1 dead only during SPINUP.
      setFan(1, 0, 0);
      step(1'b1); step(1'b1);
      stepUntilWin(2);
      check("fan1_spinup_status", 32'(bus.FanFailStatus), 32'h0);
      stepUntilWin(SPINW);
      check("fan1_spinup_end_beep", 32'(bus.Beep), 32'h0);
      setFan(1, 6, 6);
      stepUntilWin(SPINW + 3);
      check("fan1_alive_status", 32'(bus.FanFailStatus), 32'h0);

      // Fan 3 fails, then gets masked.
      setFan(3, 0, 0);
      stepUntilWin(winEnds + 2);
      check("fan3_fail_status", 32'(bus.FanFailStatus), 32'h8);
      step(1'b0);
      check("fan3_beep_rise", 32'(bus.Beep), 32'h1);
      bus.FanMask = 4'b1000;
      step(1'b0);
      check("mask_status_clear", 32'(bus.FanFailStatus), 32'h0);
      step(1'b0);
      check("mask_beep_clear", 32'(bus.Beep), 32'h0);
      stepUntilWin(winEnds + 3);
      check("masked_dead_status", 32'(bus.FanFailStatus), 32'h0);

      // Unmask, alarm again, then a one-cycle reset pulse mid-alarm.
      bus.FanMask = 4'b0000;
      stepUntilWin(winEnds + 2);
      check("fan3_refail_status", 32'(bus.FanFailStatus), 32'h8);
      for (int k = 0; k < 10; k++) step(1'b0);
      step(1'b1);
      step(1'b0);
      check("midalarm_reset_status", 32'(bus.FanFailStatus), 32'h0);
      check("midalarm_reset_beep", 32'(bus.Beep), 32'h0);
      stepUntilWin(SPINW + FAILW - 1);
      check("post_reset_early_status", 32'(bus.FanFailStatus), 32'h0);
      stepUntilWin(SPINW + FAILW);
      check("post_reset_status", 32'(bus.FanFailStatus), 32'h8);
      step(1'b0);
      check("post_reset_beep", 32'(bus.Beep), 32'h1);

      // Randomized segments checked by the model every cycle.
      for (int seg = 0; seg < 40; seg++) begin
         int len;
         for (int i = 0; i < FAN_NUM; i++) begin
            case ($urandom_range(0, 3))
               0: setFan(i, 0, 0);
               1: setFan(i, $urandom_range(2, 8), $urandom_range(2, 8));
               2: setFan(i, $urandom_range(12, 20), $urandom_range(12, 20));
               default: setFan(i, $urandom_range(2, 40), $urandom_range(2, 40));
            endcase
         end
         bus.FanMask = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
         if ($urandom_range(0, 14) == 0) step(1'b1);
         len = $urandom_range(100, 600);
         for (int k = 0; k < len; k++) step(1'b0);
      end

      step(1'b0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
